// File: rtl/rs_encoder.sv
// Systematic RS(n,k) encoder over GF(2^8) with generator roots alpha^1..alpha^2t.
// Latency: 1 cycle from message acceptance to codeword symbol; 2t parity symbols follow the last message symbol.
// Backpressure: one-entry output register; msg_ready drops while the output is stalled, during parity and in reset.
module rs_encoder #(
    parameter int n = 255,
    parameter int k = 239,
    parameter int t = 8,
    parameter int m = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         msg_valid,
    input  logic [m-1:0] msg_in,
    output logic         msg_ready,
    output logic         code_valid,
    output logic [m-1:0] code_data,
    output logic         code_sop,
    output logic         code_eop,
    input  logic         code_ready
);
    localparam int NP = 2 * t;
    localparam int CW = $clog2(n);
    // Low bits of the field polynomial x^8+x^4+x^3+x^2+1 (the x^8 term is implicit).
    localparam logic [m-1:0] PRIM_LOW = m'(8'h1D);

    // Shift-and-add multiply in GF(2^m), reduced as it goes.
    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m-1:0] r;
        r = '0;
        for (int i = m - 1; i >= 0; i--) begin
            r = {r[m-2:0], 1'b0} ^ (r[m-1] ? PRIM_LOW : '0);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // g(x) = prod (x + alpha^i), i = 1..2t; returns g0..g(2t-1), the monic top term is implied.
    function automatic logic [NP*m-1:0] gen_poly();
        logic [m-1:0]    g [0:NP];
        logic [m-1:0]    root;
        logic [NP*m-1:0] r;
        for (int j = 0; j <= NP; j++) g[j] = '0;
        g[0] = m'(1);
        root = m'(1);
        for (int i = 1; i <= NP; i++) begin
            root = gf_mul(root, m'(2));
            for (int j = NP; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(root, g[j]);
            g[0] = gf_mul(root, g[0]);
        end
        for (int j = 0; j < NP; j++) r[j*m +: m] = g[j];
        return r;
    endfunction

    localparam logic [NP*m-1:0] G = gen_poly();

    typedef enum logic {MSG, PAR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] sym_cnt;
    logic [m-1:0]  p   [0:NP-1];
    logic [m-1:0]  gfb [0:NP-1];
    logic [m-1:0]  fb;
    logic          load_en, accept, par_load, last_msg, last_sym;

    assign load_en  = !code_valid || code_ready;
    assign fb       = msg_in ^ p[NP-1];
    assign last_msg = (sym_cnt == CW'(k - 1));
    assign last_sym = (sym_cnt == CW'(n - 1));

    // Next state, input handshake and output-load strobes.
    always_comb begin
        state_nxt = state;
        msg_ready = 1'b0;
        accept    = 1'b0;
        par_load  = 1'b0;
        case (state)
            MSG: begin
                msg_ready = load_en && !rst_in;
                accept    = msg_valid && msg_ready;
                if (accept && last_msg) state_nxt = PAR;
            end
            PAR: begin
                par_load = load_en;
                if (par_load && last_sym) state_nxt = MSG;
            end
            default: state_nxt = MSG;
        endcase
    end

    // Feedback symbol scaled by every generator coefficient.
    always_comb begin
        for (int i = 0; i < NP; i++) gfb[i] = gf_mul(G[i*m +: m], fb);
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= MSG;
        else        state <= state_nxt;
    end

    // Output register and symbol counter; both freeze while the output is stalled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sym_cnt    <= '0;
            code_valid <= 1'b0;
            code_data  <= '0;
            code_sop   <= 1'b0;
            code_eop   <= 1'b0;
        end else if (load_en) begin
            if (accept || par_load) begin
                code_valid <= 1'b1;
                code_data  <= accept ? msg_in : p[NP-1];
                code_sop   <= (sym_cnt == '0);
                code_eop   <= last_sym;
                sym_cnt    <= last_sym ? '0 : sym_cnt + 1'b1;
            end else begin
                code_valid <= 1'b0;
                code_sop   <= 1'b0;
                code_eop   <= 1'b0;
            end
        end
    end

    // Parity LFSR: divides during the message, then shifts out and self-clears during parity.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NP; i++) p[i] <= '0;
        end else if (accept) begin
            p[0] <= gfb[0];
            for (int i = 1; i < NP; i++) p[i] <= p[i-1] ^ gfb[i];
        end else if (par_load) begin
            p[0] <= '0;
            for (int i = 1; i < NP; i++) p[i] <= p[i-1];
        end
    end
endmodule

// File: tb/tb_rs_encoder.sv
// Randomized bench for rs_encoder against a log/antilog-table RS(255,239) model.
// Latency: n/a (bench).
// Backpressure: drives random msg_valid gaps and code_ready stalls.
module tb_rs_encoder;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int N  = 255;
    localparam int K  = 239;
    localparam int T  = 8;
    localparam int M  = 8;
    localparam int NP = 2 * T;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         msg_valid;
    logic [M-1:0] msg_in;
    logic         msg_ready;
    logic         code_valid;
    logic [M-1:0] code_data;
    logic         code_sop;
    logic         code_eop;
    logic         code_ready;

    int checks = 0;
    int errors = 0;

    int         exp_tab [0:254];
    int         log_tab [0:255];
    logic [7:0] g_tb    [0:NP];
    logic [7:0] tx_msg  [0:K-1];
    logic [7:0] tx_cw   [0:N-1];
    logic [7:0] rx_buf  [0:N-1];

    logic [7:0] send_q [$];
    logic [7:0] exp_q  [$];
    logic [7:0] got_q  [$];
    bit         sop_q  [$];
    bit         eop_q  [$];

    int cyc = 0;
    int first_hs = -1;
    int last_hs = -1;
    int stall_bad = 0;
    int lat_bad = 0;

    rs_encoder #(.n(N), .k(K), .t(T), .m(M)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .msg_valid  (msg_valid),
        .msg_in     (msg_in),
        .msg_ready  (msg_ready),
        .code_valid (code_valid),
        .code_data  (code_data),
        .code_sop   (code_sop),
        .code_eop   (code_eop),
        .code_ready (code_ready)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        return 8'(exp_tab[(log_tab[a] + log_tab[b]) % 255]);
    endfunction

    // Antilog/log tables, then g(x) expanded as a product of (x + alpha^i) factors.
    task automatic build_tables();
        int v;
        logic [7:0] nxt [0:NP];
        v = 1;
        for (int i = 0; i < 256; i++) log_tab[i] = 0;
        for (int i = 0; i < 255; i++) begin
            exp_tab[i] = v;
            log_tab[v] = i;
            v = v << 1;
            if (v >= 256) v = v ^ 'h11D;
        end
        for (int j = 0; j <= NP; j++) g_tb[j] = 8'd0;
        g_tb[0] = 8'd1;
        for (int i = 1; i <= NP; i++) begin
            for (int j = 0; j <= NP; j++) nxt[j] = 8'd0;
            for (int j = 0; j < i; j++) begin
                nxt[j+1] = nxt[j+1] ^ g_tb[j];
                nxt[j]   = nxt[j] ^ gmul(g_tb[j], 8'(exp_tab[i]));
            end
            for (int j = 0; j <= NP; j++) g_tb[j] = nxt[j];
        end
    endtask

    // Polynomial long division of x^16*M(x) by g(x); remainder appended highest degree first.
    task automatic encode();
        logic [7:0] d [0:N-1];
        logic [7:0] c;
        for (int i = 0; i < N; i++) d[i] = (i < K) ? tx_msg[i] : 8'd0;
        for (int i = 0; i < K; i++) begin
            c = d[i];
            if (c != 8'd0)
                for (int j = 0; j <= NP; j++) d[i+j] = d[i+j] ^ gmul(c, g_tb[NP-j]);
        end
        for (int i = 0; i < N; i++) tx_cw[i] = (i < K) ? tx_msg[i] : d[i];
    endtask

    // Number of nonzero syndromes S1..S16 of rx_buf (Horner evaluation at alpha^i).
    function automatic int syn_count();
        int cnt;
        logic [7:0] s;
        cnt = 0;
        for (int i = 1; i <= NP; i++) begin
            s = 8'd0;
            for (int j = 0; j < N; j++) s = gmul(s, 8'(exp_tab[i])) ^ rx_buf[j];
            if (s != 8'd0) cnt++;
        end
        return cnt;
    endfunction

    // kind 0: all zero, 1: single 0x01 in the last message slot, 2: random.
    task automatic make_frame(input int kind);
        for (int i = 0; i < K; i++) tx_msg[i] = (kind == 2) ? 8'($urandom_range(255)) : 8'd0;
        if (kind == 1) tx_msg[K-1] = 8'h01;
        encode();
        for (int i = 0; i < K; i++) send_q.push_back(tx_msg[i]);
        for (int i = 0; i < N; i++) exp_q.push_back(tx_cw[i]);
    endtask

    task automatic clear_q();
        send_q.delete();
        exp_q.delete();
        got_q.delete();
        sop_q.delete();
        eop_q.delete();
        first_hs = -1;
        last_hs = -1;
    endtask

    task automatic drive(input string tag, input int gap_pct, input int stall_pct,
                         input int stop_in, input int stop_out, input int want);
        bit presenting, was_stall, prev_acc, done;
        logic [7:0] held, prev_sym;
        int accepted;
        presenting = 0; was_stall = 0; prev_acc = 0; done = 0;
        held = 8'd0; prev_sym = 8'd0; accepted = 0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk_in);
            if ((stop_in >= 0 && accepted >= stop_in) ||
                (stop_out >= 0 && got_q.size() >= stop_out) ||
                got_q.size() >= want) begin
                done = 1;
            end else begin
                code_ready = ($urandom_range(99) >= stall_pct);
                if (!presenting && send_q.size() > 0) presenting = ($urandom_range(99) >= gap_pct);
                msg_valid = presenting;
                msg_in = presenting ? send_q[0] : 8'($urandom);
                #1;
                if (was_stall && code_data !== held) stall_bad++;
                if (prev_acc && (code_valid !== 1'b1 || code_data !== prev_sym)) lat_bad++;
                was_stall = code_valid && !code_ready;
                held = code_data;
                cyc++;
                if (code_valid && code_ready) begin
                    got_q.push_back(code_data);
                    sop_q.push_back(code_sop);
                    eop_q.push_back(code_eop);
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end
                prev_acc = msg_valid && msg_ready;
                if (prev_acc) begin
                    prev_sym = msg_in;
                    void'(send_q.pop_front());
                    accepted++;
                    presenting = 0;
                end
            end
        end
        msg_valid = 1'b0;
        check_val({tag, "_done"}, 32'(done), 1);
    endtask

    task automatic check_frames(input string tag, input int nfr);
        int mism, flag_bad, syn_bad, lim;
        mism = 0; flag_bad = 0; syn_bad = 0;
        check_val({tag, "_count"}, got_q.size(), nfr * N);
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            if (got_q[i] !== exp_q[i]) mism++;
            if (sop_q[i] != (i % N == 0)) flag_bad++;
            if (eop_q[i] != (i % N == N - 1)) flag_bad++;
        end
        check_val({tag, "_data_mismatches"}, mism, 0);
        check_val({tag, "_flag_errors"}, flag_bad, 0);
        for (int f = 0; f < lim / N; f++) begin
            for (int j = 0; j < N; j++) rx_buf[j] = got_q[f*N + j];
            if (syn_count() != 0) syn_bad++;
        end
        check_val({tag, "_nonzero_syndrome_frames"}, syn_bad, 0);
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_valid"}, 32'(code_valid), 0);
        check_val({tag, "_data"}, 32'(code_data), 0);
        check_val({tag, "_sop"}, 32'(code_sop), 0);
        check_val({tag, "_eop"}, 32'(code_eop), 0);
        check_val({tag, "_ready"}, 32'(msg_ready), 0);
    endtask

    initial begin
        int pos;
        build_tables();
        rst_in = 1'b1;
        msg_valid = 1'b0;
        msg_in = 8'd0;
        code_ready = 1'b0;
        #3;
        check_cleared("reset");
        #14 rst_in = 1'b0;

        // All-zero message: all-zero codeword, 255 contiguous symbols.
        make_frame(0);
        drive("zero", 0, 0, -1, -1, N);
        check_frames("zero", 1);
        check_val("zero_span", 32'(last_hs - first_hs + 1), N);
        clear_q();

        // Impulse in the lowest message degree: parity equals g15..g0.
        make_frame(1);
        drive("imp", 0, 0, -1, -1, N);
        check_frames("imp", 1);
        if (got_q.size() == N)
            for (int i = 0; i < NP; i++)
                check_val($sformatf("imp_parity_g%0d", NP - 1 - i), 32'(got_q[K+i]), 32'(g_tb[NP-1-i]));
        clear_q();

        // Random frames with input gaps and output stalls.
        make_frame(2);
        make_frame(2);
        drive("gaps", 30, 30, -1, -1, 2 * N);
        check_frames("gaps", 2);
        check_val("stall_hold_violations", stall_bad, 0);
        check_val("latency_violations", lat_bad, 0);
        clear_q();

        // Three back-to-back frames at full rate, no bubbles.
        make_frame(2);
        make_frame(2);
        make_frame(2);
        drive("b2b", 0, 0, -1, -1, 3 * N);
        check_frames("b2b", 3);
        check_val("b2b_span", 32'(last_hs - first_hs + 1), 3 * N);
        if (got_q.size() == 3 * N) begin
            for (int j = 0; j < N; j++) rx_buf[j] = got_q[2*N + j];
            for (int e = 0; e < 8; e++) begin
                pos = e * 31 + $urandom_range(30);
                rx_buf[pos] = rx_buf[pos] ^ 8'($urandom_range(255, 1));
            end
            check_val("errors_detected", 32'(syn_count() > 0), 1);
        end
        clear_q();

        // Asynchronous reset at message symbol 100.
        make_frame(2);
        drive("rst_msg", 10, 10, 100, -1, N);
        #2.3 rst_in = 1'b1;
        #1 check_cleared("rst_msg");
        #6.1 rst_in = 1'b0;
        clear_q();

        // Asynchronous reset at parity symbol 5.
        make_frame(2);
        drive("rst_par", 0, 20, -1, K + 5, N);
        #3.7 rst_in = 1'b1;
        #1 check_cleared("rst_par");
        #7.4 rst_in = 1'b0;
        #0.5 check_val("post_rst_ready", 32'(msg_ready), 1);
        clear_q();

        // Full frame after reset encodes cleanly and starts with sop.
        make_frame(2);
        drive("post", 20, 20, -1, -1, N);
        check_frames("post", 1);
        check_val("final_stall_hold_violations", stall_bad, 0);
        check_val("final_latency_violations", lat_bad, 0);
        clear_q();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
